// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller and the interrupt mux.
// Holds the register select codes, the FSM state encoding and the vector address.
package interrupt_controller_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_ACTIVE  = 2'd3;

  localparam logic [10:0] IRQ_VECTOR = 11'h004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pending_bank.sv
// Edge history and pending bits for the interrupt sources.
// Ports: clk_i, rst_ni, irq_src_i (levels), clr_i (clear mask), pending_o.
module irq_pending_bank #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic [NUM_SRC-1:0] clr_i,
  output logic [NUM_SRC-1:0] pending_o
);

  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] rise;

  assign rise = irq_src_i & ~prev_q;

  // A fresh edge beats any clear arriving in the same cycle.
  assign pending_d = (pending_q & ~clr_i) | rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= irq_src_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: pending/mask registers, one request
// to the decoder, ack/return tracking. Ports: instr_clock, reset_bar,
// irq_src, int_ack, int_return, reg_* bus, int_request, active_id.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               instr_clock,
  input  logic               reset_bar,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               int_ack,
  input  logic               int_return,
  input  logic               reg_we,
  input  logic [1:0]         reg_sel,
  input  logic [15:0]        reg_wdata,
  output logic [15:0]        reg_rdata,
  output logic               int_request,
  output logic [ID_W-1:0]    active_id
);

  function automatic logic [ID_W-1:0] lowest_set(
    input logic [NUM_SRC-1:0] v
  );
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  irq_state_e         state_q;
  irq_state_e         state_d;
  logic [ID_W-1:0]    active_id_q;
  logic [ID_W-1:0]    active_id_d;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] mask_d;
  logic               gen_q;
  logic               gen_d;

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [ID_W-1:0]    winner;
  logic               ack_take;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] clr;
  logic               unused_wdata;

  assign eligible = pending & mask_q & {NUM_SRC{gen_q}};
  assign any_elig = |eligible;
  assign winner   = lowest_set(eligible);

  // An ack only counts while something is still eligible.
  assign ack_take = (state_q == ST_REQUEST) & int_ack & any_elig;

  irq_pending_bank #(
    .NUM_SRC (NUM_SRC)
  ) u_bank (
    .clk_i     (instr_clock),
    .rst_ni    (reset_bar),
    .irq_src_i (irq_src),
    .clr_i     (clr),
    .pending_o (pending)
  );

  always_ff @(posedge instr_clock or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_elig) state_d = ST_REQUEST;
      end
      ST_REQUEST: begin
        if (ack_take)       state_d = ST_SERVICE;
        else if (!any_elig) state_d = ST_IDLE;
      end
      ST_SERVICE: begin
        if (int_return) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active_id_d = active_id_q;
    clr         = w1c;
    if (ack_take) begin
      active_id_d = winner;
      clr         = w1c | (NUM_SRC'(1) << winner);
    end
  end

  always_comb begin
    mask_d = mask_q;
    gen_d  = gen_q;
    w1c    = '0;
    if (reg_we) begin
      unique case (1'b1)
        (reg_sel == REG_CTRL):    gen_d  = reg_wdata[0];
        (reg_sel == REG_MASK):    mask_d = reg_wdata[NUM_SRC-1:0];
        (reg_sel == REG_PENDING): w1c    = reg_wdata[NUM_SRC-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge instr_clock or negedge reset_bar) begin
    if (!reset_bar) begin
      active_id_q <= '0;
      mask_q      <= '0;
      gen_q       <= 1'b0;
    end else begin
      active_id_q <= active_id_d;
      mask_q      <= mask_d;
      gen_q       <= gen_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (1'b1)
      (reg_sel == REG_CTRL): begin
        reg_rdata[0]   = gen_q;
        reg_rdata[9:8] = state_q;
      end
      (reg_sel == REG_MASK): begin
        reg_rdata[NUM_SRC-1:0] = mask_q;
      end
      (reg_sel == REG_PENDING): begin
        reg_rdata[NUM_SRC-1:0] = pending;
      end
      default: begin
        reg_rdata[15]     = (state_q == ST_SERVICE);
        reg_rdata[ID_W-1:0] = active_id_q;
      end
    endcase
  end

  // REQUEST is entered and left on clock edges, so this is a registered output.
  assign int_request = (state_q == ST_REQUEST);
  assign active_id   = active_id_q;

  assign unused_wdata = ^reg_wdata[15:NUM_SRC];

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller.
// Directed vectors plus a per-cycle comparison against a behavioural model.
module tb_interrupt_controller;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        int_ack;
  logic        int_return;
  logic        reg_we;
  logic [1:0]  reg_sel;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        int_request;
  logic [3:0]  active_id;

  int total = 0;
  int bad   = 0;

  interrupt_controller #(.NUM_SRC(8), .ID_W(4)) dut (
    .instr_clock (clk),
    .reset_bar   (rst_n),
    .irq_src     (irq_src),
    .int_ack     (int_ack),
    .int_return  (int_return),
    .reg_we      (reg_we),
    .reg_sel     (reg_sel),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .int_request (int_request),
    .active_id   (active_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: software-visible view of the block.
  int         m_state = 0;
  logic [7:0] m_pend  = 0;
  logic [7:0] m_mask  = 0;
  logic       m_gen   = 0;
  logic [7:0] m_prev  = 0;
  int         m_aid   = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] edg;
    logic [7:0] elig;
    logic [7:0] np;
    int         win;
    if (!rst_n) begin
      m_state = 0;
      m_pend  = 0;
      m_mask  = 0;
      m_gen   = 0;
      m_prev  = 0;
      m_aid   = 0;
    end else begin
      edg  = irq_src & ~m_prev;
      elig = m_gen ? (m_pend & m_mask) : 8'h00;
      win  = -1;
      for (int i = 7; i >= 0; i--) if (elig[i]) win = i;
      np = m_pend;
      if (reg_we && reg_sel == 2'd2) np = np & ~reg_wdata[7:0];
      if (m_state == 0) begin
        if (win >= 0) m_state = 1;
      end else if (m_state == 1) begin
        if (int_ack && win >= 0) begin
          m_aid   = win;
          np[win] = 1'b0;
          m_state = 2;
        end else if (win < 0) begin
          m_state = 0;
        end
      end else begin
        if (int_return) m_state = 0;
      end
      m_pend = np | edg;
      if (reg_we && reg_sel == 2'd0) m_gen  = reg_wdata[0];
      if (reg_we && reg_sel == 2'd1) m_mask = reg_wdata[7:0];
      m_prev = irq_src;
    end
  end

  function automatic logic [15:0] m_read(input logic [1:0] sel);
    logic [15:0] r;
    r = 16'h0000;
    case (sel)
      2'd0: r = {6'd0, 2'(m_state), 7'd0, m_gen};
      2'd1: r = {8'd0, m_mask};
      2'd2: r = {8'd0, m_pend};
      default: r = {(m_state == 2), 11'd0, 4'(m_aid)};
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    chk("cyc_req", 32'(int_request), 32'(m_state == 1));
    chk("cyc_aid", 32'(active_id), 32'(m_aid));
    chk("cyc_rdata", 32'(reg_rdata), 32'(m_read(reg_sel)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [15:0] d);
    reg_we    = 1'b1;
    reg_sel   = sel;
    reg_wdata = d;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input logic [15:0] exp,
                    input string name);
    reg_sel = sel;
    #1;
    chk(name, 32'(reg_rdata), 32'(exp));
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic ret();
    int_return = 1'b1;
    tick();
    int_return = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    irq_src    = '0;
    int_ack    = 1'b0;
    int_return = 1'b0;
    reg_we     = 1'b0;
    reg_sel    = 2'd0;
    reg_wdata  = '0;
    #1;
    chk("rst_req", 32'(int_request), 0);
    chk("rst_aid", 32'(active_id), 0);
    rd(2'd0, 16'h0000, "rst_ctrl");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic request / ack / return
    wr(2'd1, 16'h0001);
    wr(2'd0, 16'h0001);
    irq_src = 8'h01;
    tick();
    chk("basic_req_e1", 32'(int_request), 0);
    tick();
    chk("basic_req_e2", 32'(int_request), 1);
    ack();
    chk("basic_ack_req", 32'(int_request), 0);
    chk("basic_ack_aid", 32'(active_id), 0);
    rd(2'd2, 16'h0000, "basic_pend");
    rd(2'd0, 16'h0201, "basic_ctrl_svc");
    tick();
    ret();
    rd(2'd0, 16'h0001, "basic_ctrl_idle");
    irq_src = 8'h00;
    tick();

    // Priority between two simultaneous sources
    wr(2'd1, 16'h00FF);
    irq_src = 8'h24;
    tick();
    tick();
    chk("prio_req", 32'(int_request), 1);
    ack();
    chk("prio_aid1", 32'(active_id), 2);
    irq_src = 8'h00;
    ret();
    chk("prio_ret_req", 32'(int_request), 0);
    tick();
    chk("prio_rereq", 32'(int_request), 1);
    ack();
    chk("prio_aid2", 32'(active_id), 5);
    rd(2'd3, 16'h8005, "prio_active");
    ret();
    tick();

    // Masking and global gating
    wr(2'd1, 16'h0000);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    tick();
    chk("mask_noreq", 32'(int_request), 0);
    rd(2'd2, 16'h0010, "mask_pend");
    wr(2'd1, 16'h0010);
    chk("mask_req0", 32'(int_request), 0);
    tick();
    chk("mask_req1", 32'(int_request), 1);
    wr(2'd0, 16'h0000);
    chk("gen_off_hold", 32'(int_request), 1);
    tick();
    chk("gen_off_drop", 32'(int_request), 0);
    rd(2'd0, 16'h0000, "gen_off_ctrl");
    rd(2'd2, 16'h0010, "gen_off_pend");
    wr(2'd2, 16'h0010);
    wr(2'd0, 16'h0001);
    rd(2'd2, 16'h0000, "w1c_clear");

    // W1C colliding with a new edge
    wr(2'd1, 16'h0000);
    irq_src = 8'h08;
    wr(2'd2, 16'hFF08);
    rd(2'd2, 16'h0008, "w1c_collide");
    wr(2'd2, 16'h0008);
    rd(2'd2, 16'h0000, "w1c_after");
    irq_src = 8'h00;
    tick();

    // Edges arriving while in service
    wr(2'd1, 16'h00FF);
    irq_src = 8'h40;
    tick();
    tick();
    chk("svc_req", 32'(int_request), 1);
    ack();
    chk("svc_aid6", 32'(active_id), 6);
    irq_src = 8'h42;
    tick();
    tick();
    tick();
    chk("svc_noreq", 32'(int_request), 0);
    rd(2'd2, 16'h0002, "svc_pend");
    ret();
    chk("svc_ret_req", 32'(int_request), 0);
    tick();
    chk("svc_rereq", 32'(int_request), 1);
    ack();
    chk("svc_aid1", 32'(active_id), 1);
    ret();
    tick();
    tick();
    chk("level_norepend", 32'(int_request), 0);
    rd(2'd2, 16'h0000, "level_pend");
    irq_src = 8'h00;
    tick();

    // Async reset in the middle of service
    irq_src = 8'h80;
    tick();
    irq_src = 8'h00;
    tick();
    chk("arst_req", 32'(int_request), 1);
    ack();
    rd(2'd3, 16'h8007, "arst_active");
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_req0", 32'(int_request), 0);
    chk("arst_aid0", 32'(active_id), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      rd(2'(s), 16'h0000, "arst_regs");
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Drives the CPU's interrupt-request input, which is currently tied to 0. The block collects NUM_SRC peripheral interrupt lines and holds a pending/mask register set that software can access. It raises a single request to the instruction decoder. It then tracks the acknowledge (the cycle the decoder selects vector 11'h004 on the interrupt mux) and the return-from-interrupt that ends service. Only one interrupt is serviced at a time; there is no nesting.

Parameters:
NUM_SRC, 8, number of interrupt source lines (1..15)
ID_W, 4, width of the source-ID field

Ports:
instr_clock  in  1  instruction clock; all state updates on its rising edge
reset_bar  in  1  asynchronous active-low reset
irq_src  in  NUM_SRC  level lines from peripherals; a rising edge raises an interrupt
int_ack  in  1  decoder took the vector (control_int_mux high), one cycle
int_return  in  1  decoder executing return-from-interrupt, one cycle
reg_we  in  1  software register write strobe
reg_sel  in  2  register select: 0 CTRL, 1 MASK, 2 PENDING, 3 ACTIVE
reg_wdata  in  16  write data
reg_rdata  out  16  read data, combinational from reg_sel
int_request  out  1  registered request to decoder
active_id  out  ID_W  ID of the source currently in service

Behaviour:
- Reset (reset_bar low, async): state IDLE; int_request=0; active_id=0; pending, mask, global_en, and edge-history all 0.
- Edge detect: prev[i] is registered each cycle. An edge is irq_src[i] & ~prev[i]. An edge sets pending[i] on the next clock regardless of mask or state.
- eligible = pending & mask & {NUM_SRC{global_en}}. winner = lowest index set in eligible.
- FSM, 3 states:
  - IDLE: if eligible != 0, go to REQUEST and set int_request=1 on the same edge (1-cycle latency from the pending bit).
  - REQUEST: hold int_request=1.
    - On int_ack: active_id<=winner, clear pending[winner], int_request<=0, go to IN_SERVICE.
    - If eligible becomes 0 with no ack (software cleared the bit or masked it): int_request<=0, go to IDLE.
    - Ack and eligible==0 in the same cycle: the ack wins only if eligible was nonzero in that cycle; otherwise the ack is ignored.
  - IN_SERVICE: int_request=0. On int_return go to IDLE; active_id is retained until the next ack. Re-request is possible on the following cycle.
- int_ack outside REQUEST is ignored. int_return outside IN_SERVICE is ignored.
- Register writes (reg_we, effective next edge):
  - CTRL: bit0 = global_en.
  - MASK: low NUM_SRC bits.
  - PENDING: write-1-to-clear.
  - ACTIVE: read-only; writes are ignored.
- Collisions on one bit in the same cycle:
  - New edge vs W1C clear: set wins.
  - New edge vs ack-clear: set wins (the bit stays pending).
- Register reads:
  - CTRL: bit0 global_en; bits 9:8 state (IDLE=0, REQUEST=1, IN_SERVICE=2); other bits 0.
  - MASK and PENDING: zero-extended.
  - ACTIVE: bit15 = in service; bits ID_W-1:0 = active_id.
- Unused high bits of reg_wdata are ignored.
- Reset asserted mid-request or mid-service returns the block to IDLE immediately. The CPU-side vector state is the decoder's concern.

Decomposition:
- Shared package/header holds:
  - register select codes: CTRL=2'd0, MASK=2'd1, PENDING=2'd2, ACTIVE=2'd3
  - FSM state encodings
  - interrupt vector constant 11'h004, shared with the interrupt mux
- Natural sub-module: irq_pending_bank. It holds the edge-history and pending registers with set-wins W1C logic, and outputs pending[NUM_SRC-1:0].
- The priority encoder is a function inside interrupt_controller.

Test Plan:
- Basic request: reset; write MASK=8'h01, CTRL=1; pulse irq_src[0]. Expect int_request=1 two edges after the source edge. Ack: int_request=0, active_id=0, PENDING=0, CTRL[9:8]=2. Then int_return: CTRL[9:8]=0.
- Priority: MASK=8'hFF; raise irq_src[5] and irq_src[2] together. Ack gives active_id=2. After int_return, the request reasserts next cycle. Second ack gives active_id=5.
- Masking and gating: MASK=0 with a source edge: pending bit set, no request. Set MASK bit: request on the next cycle. Clear global_en while in REQUEST: request drops, state returns to IDLE, pending is kept.
- W1C collision: write PENDING=8'h08 in the same cycle as an irq_src[3] edge. pending[3] remains 1.
- Edges during service: in IN_SERVICE, pulse irq_src[1]. No request until int_return; then int_request=1 the next cycle. A level held high does not re-pend after its ack.
- Async reset mid-service: drop reset_bar between clock edges. Outputs are 0 immediately and all registers read 0 after release.
